// File: rtl/score_keeper.sv
// -----------------------------------------------------------------------------
// score_keeper
//   Receives the {red, blue} score level from the scoring logic and keeps
//   per-team two-digit BCD totals. It detects the end of the game (red win,
//   blue win or draw) and drives a registered, time-multiplexed 4-digit scan
//   for a seven-segment display. The winner's digits blink once the game is
//   over.
//
// Parameters:
//   WIN_SCORE    - point total that ends the game (1..99)
//   SCAN_DIV     - clock cycles each digit stays enabled (>= 2)
//   BLINK_FRAMES - full scan frames per blink half-period (>= 1)
//
// Ports:
//   clk       in   1  system clock, rising edge
//   rst_n     in   1  asynchronous active-low reset
//   score     in   2  {red, blue} point level; may be held high for many cycles
//   clear     in   1  synchronous new-game request, active high
//   red_bcd   out  8  {tens, ones} red total
//   blue_bcd  out  8  {tens, ones} blue total
//   winner    out  2  10 red, 01 blue, 11 draw, 00 in play
//   game_over out  1  high in any terminal state
//   seg_an    out  4  active-low one-hot digit enable
//   seg_digit out  4  BCD value of the enabled digit, 4'hF = blank
// -----------------------------------------------------------------------------
module score_keeper #(
    parameter int WIN_SCORE    = 5,
    parameter int SCAN_DIV     = 1000,
    parameter int BLINK_FRAMES = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] score,
    input  logic       clear,
    output logic [7:0] red_bcd,
    output logic [7:0] blue_bcd,
    output logic [1:0] winner,
    output logic       game_over,
    output logic [3:0] seg_an,
    output logic [3:0] seg_digit
);

    typedef enum logic [1:0] {
        PLAY,
        RED_WIN,
        BLUE_WIN,
        DRAW
    } state_t;

    localparam logic [7:0] WIN_BCD = {4'(WIN_SCORE / 10), 4'(WIN_SCORE % 10)};
    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [3:0] BLANK = 4'hF;

    state_t             state, state_n;
    logic [1:0]         score_q;
    logic [7:0]         red_n, blue_n;
    logic [CNT_W-1:0]   scan_cnt, scan_cnt_n;
    logic [1:0]         idx, idx_n;
    logic [FRM_W-1:0]   frame_cnt, frame_cnt_n;
    logic               blink, blink_n;
    logic [3:0]         seg_an_n, seg_digit_n;

    logic rise_r, rise_b;
    logic red_hit, blue_hit;
    logic scan_tc, frame_wrap, blank_now;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9) begin
            bcd_inc = {v[7:4] + 4'd1, 4'd0};
        end else begin
            bcd_inc = {v[7:4], v[3:0] + 4'd1};
        end
    endfunction

    // score_q resets to 11 so a level already high when reset releases is
    // not seen as a rise.
    assign rise_r = score[1] & ~score_q[1];
    assign rise_b = score[0] & ~score_q[0];

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_n  = state;
        red_n    = red_bcd;
        blue_n   = blue_bcd;
        red_hit  = 1'b0;
        blue_hit = 1'b0;

        if (clear) begin
            state_n = PLAY;
            red_n   = 8'h00;
            blue_n  = 8'h00;
        end else if (state == PLAY) begin
            if (rise_r) red_n  = bcd_inc(red_bcd);
            if (rise_b) blue_n = bcd_inc(blue_bcd);
            red_hit  = (red_n == WIN_BCD);
            blue_hit = (blue_n == WIN_BCD);
            if (red_hit && blue_hit) state_n = DRAW;
            else if (red_hit)        state_n = RED_WIN;
            else if (blue_hit)       state_n = BLUE_WIN;
        end
    end

    // Scan and blink sequencing. Display outputs are computed from the
    // next-cycle index, totals and phase so the registered seg_an/seg_digit
    // always agree with the state visible on the same edge.
    always_comb begin
        scan_tc     = (scan_cnt == CNT_W'(SCAN_DIV - 1));
        scan_cnt_n  = scan_tc ? '0 : scan_cnt + 1'b1;
        idx_n       = scan_tc ? idx + 2'd1 : idx;
        frame_wrap  = scan_tc && (idx == 2'd3);
        frame_cnt_n = frame_cnt;
        blink_n     = blink;

        if (state_n == PLAY) begin
            frame_cnt_n = '0;
            blink_n     = 1'b0;
        end else if (frame_wrap) begin
            if (frame_cnt == FRM_W'(BLINK_FRAMES - 1)) begin
                frame_cnt_n = '0;
                blink_n     = ~blink;
            end else begin
                frame_cnt_n = frame_cnt + 1'b1;
            end
        end

        // Index 0/1 are blue's digits, 2/3 are red's: idx_n[1] selects red.
        blank_now = blink_n && ((state_n == DRAW) ||
                                (state_n == RED_WIN  &&  idx_n[1]) ||
                                (state_n == BLUE_WIN && !idx_n[1]));

        seg_an_n = ~(4'b0001 << idx_n);
        unique case (idx_n)
            2'd0:    seg_digit_n = blue_n[3:0];
            2'd1:    seg_digit_n = blue_n[7:4];
            2'd2:    seg_digit_n = red_n[3:0];
            default: seg_digit_n = red_n[7:4];
        endcase
        if (blank_now) seg_digit_n = BLANK;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= PLAY;
            score_q   <= 2'b11;
            red_bcd   <= 8'h00;
            blue_bcd  <= 8'h00;
            scan_cnt  <= '0;
            idx       <= 2'd0;
            frame_cnt <= '0;
            blink     <= 1'b0;
            seg_an    <= 4'b1110;
            seg_digit <= 4'h0;
        end else begin
            state     <= state_n;
            score_q   <= score;
            red_bcd   <= red_n;
            blue_bcd  <= blue_n;
            scan_cnt  <= scan_cnt_n;
            idx       <= idx_n;
            frame_cnt <= frame_cnt_n;
            blink     <= blink_n;
            seg_an    <= seg_an_n;
            seg_digit <= seg_digit_n;
        end
    end

    always_comb begin
        winner    = 2'b00;
        game_over = 1'b1;
        unique case (state)
            RED_WIN:  winner = 2'b10;
            BLUE_WIN: winner = 2'b01;
            DRAW:     winner = 2'b11;
            default:  game_over = 1'b0;
        endcase
    end

endmodule
